// File: rtl/valid_stream_collector.sv
// Credit-gated receiver for a fixed-latency valid-only pipe: reserves a credit per launch,
// buffers arrivals in order, releases the credit on pop. out_vld lags a push by one cycle.
module valid_stream_collector #(
   parameter int width = 8,
   parameter int depth = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     launch,
   output logic                     launch_ok,
   input  logic                     in_vld,
   input  logic [width-1:0]         in_data,
   output logic                     out_vld,
   output logic [width-1:0]         out_data,
   input  logic                     out_rdy,
   output logic [$clog2(depth):0]   used,
   output logic                     overflow
);
   localparam int aw = $clog2(depth);
   localparam logic [aw:0] full_cnt = (aw+1)'(depth);

   logic [aw:0]      used_q, used_d;
   logic [aw:0]      occ_q, occ_d;
   logic [aw-1:0]    wr_ptr_q, wr_ptr_d;
   logic [aw-1:0]    rd_ptr_q, rd_ptr_d;
   logic             overflow_q, overflow_d;
   logic [width-1:0] mem_q [depth];

   logic accept, push, pop, full, wr_en;

   always_comb begin
      launch_ok  = (used_q < full_cnt);
      out_vld    = (occ_q != '0);
      full       = (occ_q == full_cnt);
      accept     = launch & launch_ok;
      push       = in_vld;
      pop        = out_vld & out_rdy;
      wr_en      = push & (~full | pop);

      used_d = used_q;
      if (accept && !pop) begin
         used_d = used_q + (aw+1)'(1);
      end else if (pop && !accept && used_q != '0) begin
         // Unsolicited arrivals (e.g. in flight across a reset) must not wrap the credit count.
         used_d = used_q - (aw+1)'(1);
      end

      occ_d = occ_q;
      if (wr_en && !pop) begin
         occ_d = occ_q + (aw+1)'(1);
      end else if (pop && !wr_en) begin
         occ_d = occ_q - (aw+1)'(1);
      end

      wr_ptr_d   = wr_en ? wr_ptr_q + aw'(1) : wr_ptr_q;
      rd_ptr_d   = pop   ? rd_ptr_q + aw'(1) : rd_ptr_q;
      overflow_d = overflow_q | (launch & ~launch_ok) | (push & full & ~pop);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         used_q     <= '0;
         occ_q      <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         overflow_q <= 1'b0;
      end else begin
         used_q     <= used_d;
         occ_q      <= occ_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         overflow_q <= overflow_d;
      end
   end

   // Storage is deliberately not reset; out_data is only meaningful with out_vld.
   always_ff @(posedge clk) begin
      if (wr_en && !rst) begin
         mem_q[wr_ptr_q] <= in_data;
      end
   end

   assign out_data = mem_q[rd_ptr_q];
   assign used     = used_q;
   assign overflow = overflow_q;

endmodule

// File: doc/valid_stream_collector.md
VALID_STREAM_COLLECTOR -- requirements
Module: valid_stream_collector

Receiving end of a fixed-latency valid-only pipeline (no backpressure inside the pipe). Credit-gates launches into the pipe and buffers arrivals for a valid/ready consumer.

Interface
REQ-001 SHALL have parameter width, default 8, meaning data bits per transfer.
REQ-002 SHALL have parameter depth, default 8, meaning buffer entries and total credits; power of two, at least 2.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port launch  input  1  upstream requests to start a transfer into the pipe this cycle.
REQ-006 SHALL have port launch_ok  output  1  a credit is free; a launch this cycle is accepted.
REQ-007 SHALL have port in_vld  input  1  pipe output carries a valid transfer this cycle.
REQ-008 SHALL have port in_data  input  width  pipe output data, meaningful only when in_vld=1.
REQ-009 SHALL have port out_vld  output  1  buffer holds at least one entry.
REQ-010 SHALL have port out_data  output  width  oldest buffered entry.
REQ-011 SHALL have port out_rdy  input  1  consumer accepts out_data this cycle.
REQ-012 SHALL have port used  output  $clog2(depth)+1  number of credits currently reserved.
REQ-013 SHALL have port overflow  output  1  sticky protocol-violation flag.

Function
REQ-014 SHALL define accept = launch & launch_ok, push = in_vld, and pop = out_vld & out_rdy.
REQ-015 SHALL drive launch_ok = (used < depth), decoded from registers only, with no combinational path from any input.
REQ-016 SHALL update used each cycle as used + accept - pop; accept and pop in the same cycle leave it unchanged.
REQ-017 SHALL hold a credit from its accepted launch until the corresponding entry is popped, covering both the in-flight and the buffered period.
REQ-018 SHALL keep a separate occupancy count; out_vld = (occupancy != 0), registered.
REQ-019 SHALL store in_data at the write pointer on push when not full, or when full with a pop in the same cycle; the write pointer wraps modulo depth.
REQ-020 SHALL present out_data from storage at the read pointer and advance the read pointer, wrapping modulo depth, on pop.
REQ-021 SHALL provide no bypass: a push into an empty buffer makes out_vld=1 on the next cycle, not the same cycle.
REQ-022 SHALL keep FIFO order; data popped equals data pushed, in sequence.
REQ-023 SHALL NOT accept launch when launch_ok=0; used is unchanged, and overflow is set if launch=1.
REQ-024 SHALL drop in_data on push with buffer full and no pop; pointers and occupancy are unchanged and overflow is set.
REQ-025 SHALL keep overflow set once set, until rst.
REQ-026 SHALL treat out_rdy while out_vld=0 as having no effect.
REQ-027 SHALL keep occupancy <= used <= depth at all times under legal upstream use (launch only with launch_ok).

Reset
REQ-028 SHALL, on rst=1 at a clock edge, clear used, occupancy, both pointers and overflow; next cycle out_vld=0, launch_ok=1, used=0, overflow=0.
REQ-029 SHALL leave storage contents unreset; out_data is don't-care while out_vld=0.
REQ-030 SHALL make rst override all same-cycle launch, push and pop; transfers in flight at reset are forgotten, and later arrivals are treated as ordinary pushes.

Verification
REQ-031 SHALL cover: depth=4, 4 accepted launches with out_rdy=0 -> used=4, launch_ok=0; 5th launch -> not accepted, overflow=1.
REQ-032 SHALL cover: pushes 0xA1,0xB2,0xC3 then out_rdy=1 -> out_data sequence A1,B2,C3; out_vld low the cycle after C3 is popped; used drops by one per pop.
REQ-033 SHALL cover: buffer full (4), push 0xD4 with pop same cycle -> occupancy stays 4, no overflow, D4 emerges last.
REQ-034 SHALL cover: buffer full, push with out_rdy=0 -> data dropped, overflow=1, remaining order intact.
REQ-035 SHALL cover: empty buffer, push 0x55 at cycle t -> out_vld=0 at t, out_vld=1 and out_data=0x55 at t+1.
REQ-036 SHALL cover: rst asserted with used=3, occupancy=2, overflow=1 -> next cycle used=0, out_vld=0, launch_ok=1, overflow=0.
